// File: rtl/aer_core_event_dispatcher.sv
// Routes one 4-phase AER event to its core(s); core-local prefix 2'b01 broadcasts to all cores.
// Optional AER_EVT_REQ_SYNC_EN inserts a 2-flop synchronizer on evt_req (latency 1 -> 3 cycles).
module aer_core_event_dispatcher #(
  parameter int CORE_NUM           = 4,
  parameter int AER_OUT_CORE_WIDTH = 8,
  localparam int IDX_W             = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                evt_req,
  input  logic [IDX_W+AER_OUT_CORE_WIDTH-1:0] evt_addr,
  output logic                                evt_ack,
  output logic [CORE_NUM-1:0]                 core_req,
  output logic [AER_OUT_CORE_WIDTH-1:0]       core_addr,
  input  logic [CORE_NUM-1:0]                 core_ack,
  output logic                                busy,
  output logic                                err_drop
);

  localparam int AW = AER_OUT_CORE_WIDTH;

  typedef enum logic [1:0] {IDLE, DISPATCH, ACK, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [CORE_NUM-1:0]   pending_q, pending_d;
  logic [CORE_NUM-1:0]   core_req_d;
  logic [AW-1:0]         core_addr_d;
  logic                  evt_ack_d, err_drop_d;
  logic                  req_in;
  logic [IDX_W-1:0]      evt_idx;
  logic [AW-1:0]         evt_local;
  logic [CORE_NUM-1:0]   dec_mask;

`ifdef AER_EVT_REQ_SYNC_EN
  logic [1:0] req_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= 2'b00;
    end else begin
      req_sync <= {req_sync[0], evt_req};
    end
  end

  assign req_in = req_sync[1];
`else
  assign req_in = evt_req;
`endif

  assign evt_idx   = evt_addr[IDX_W+AW-1:AW];
  assign evt_local = evt_addr[AW-1:0];

  // An out-of-range index matches no core, leaving the mask empty (drop path).
  always_comb begin
    dec_mask = '0;
    if (evt_local[AW-1 -: 2] == 2'b01) begin
      dec_mask = '1;
    end else begin
      for (int i = 0; i < CORE_NUM; i++) begin
        if (evt_idx == IDX_W'(i)) dec_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    core_req_d  = core_req;
    pending_d   = pending_q;
    core_addr_d = core_addr;
    evt_ack_d   = evt_ack;
    err_drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          core_addr_d = evt_local;
          if (dec_mask == '0) begin
            err_drop_d = 1'b1;
            state_d    = ACK;
          end else begin
            core_req_d = dec_mask;
            pending_d  = dec_mask;
            state_d    = DISPATCH;
          end
        end
      end
      DISPATCH: begin
        if (pending_q == '0) begin
          state_d = ACK;
        end else begin
          // A core finishes its handshake once both its req and ack are low again.
          core_req_d = core_req & ~core_ack;
          pending_d  = pending_q & (core_req | core_ack);
        end
      end
      ACK: begin
        evt_ack_d = 1'b1;
        state_d   = RELEASE;
      end
      RELEASE: begin
        if (!req_in) begin
          evt_ack_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      core_req  <= '0;
      core_addr <= '0;
      evt_ack   <= 1'b0;
      err_drop  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      core_req  <= core_req_d;
      core_addr <= core_addr_d;
      evt_ack   <= evt_ack_d;
      err_drop  <= err_drop_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
